// File: rtl/hazard_tracker.sv
// Destination-register shadow of the EX/MEM/WB stages feeding the forwarding unit.
// Detects load-use hazards against the ID instruction and counts stall cycles.
module hazard_tracker #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwen,
    input  logic             id_memread,
    input  logic             freeze,
    input  logic             flush,
    output logic [REG_W-1:0] curr_rs,
    output logic [REG_W-1:0] curr_rt,
    output logic [REG_W-1:0] rd_mem,
    output logic             wr_mem,
    output logic [REG_W-1:0] rd_wb,
    output logic             wr_wb,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_count
);

    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_wen_q, ex_wen_d;
    logic             ex_load_q, ex_load_d;

    // A load sitting in MEM is resolved by forwarding, so its load bit is not kept.
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             mem_wen_q, mem_wen_d;

    logic             wb_valid_q, wb_valid_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic             wb_wen_q, wb_wen_d;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             hz;

    assign hz = id_valid & ex_valid_q & ex_load_q & ex_wen_q &
                ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));
    assign stall_id = hz & ~flush & ~freeze;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        ex_rd_d       = ex_rd_q;
        ex_wen_d      = ex_wen_q;
        ex_load_d     = ex_load_q;
        mem_valid_d   = mem_valid_q;
        mem_rd_d      = mem_rd_q;
        mem_wen_d     = mem_wen_q;
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        wb_wen_d      = wb_wen_q;
        stall_count_d = stall_count_q;

        if (!freeze) begin
            wb_valid_d = mem_valid_q;
            wb_rd_d    = mem_rd_q;
            wb_wen_d   = mem_wen_q;

            if (flush) begin
                mem_valid_d = 1'b0;
                mem_rd_d    = '0;
                mem_wen_d   = 1'b0;
            end else begin
                mem_valid_d = ex_valid_q;
                mem_rd_d    = ex_rd_q;
                mem_wen_d   = ex_wen_q;
            end

            if (!flush && !stall_id && id_valid) begin
                ex_valid_d = 1'b1;
                ex_rs_d    = id_rs;
                ex_rt_d    = id_uses_rt ? id_rt : '0;
                ex_rd_d    = id_rd;
                // $0 must never look like a forwarding source.
                ex_wen_d   = id_regwen & (id_rd != '0);
                ex_load_d  = id_memread;
            end else begin
                ex_valid_d = 1'b0;
                ex_rs_d    = '0;
                ex_rt_d    = '0;
                ex_rd_d    = '0;
                ex_wen_d   = 1'b0;
                ex_load_d  = 1'b0;
            end

            if (stall_id && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid_q    <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_wen_q      <= 1'b0;
            ex_load_q     <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_rd_q      <= '0;
            mem_wen_q     <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_wen_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            ex_wen_q      <= ex_wen_d;
            ex_load_q     <= ex_load_d;
            mem_valid_q   <= mem_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_wen_q     <= mem_wen_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_wen_q      <= wb_wen_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign curr_rs     = ex_rs_q;
    assign curr_rt     = ex_rt_q;
    assign rd_mem      = mem_rd_q;
    assign wr_mem      = mem_valid_q & mem_wen_q;
    assign rd_wb       = wb_rd_q;
    assign wr_wb       = wb_valid_q & wb_wen_q;
    assign stall_count = stall_count_q;

endmodule
